// File: rtl/spi_fb_writer.sv
// SPI mode-0 slave that turns host write transactions into frame-buffer byte writes.
// Ports: clk, rst_n, spi_sck/spi_cs_n/spi_mosi (async pins), ram_en/ram_we/ram_addr/ram_din, busy, frame_done.
module spi_fb_writer #(
    parameter int          ADDRL     = 14,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sck,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             ram_en,
    output logic             ram_we,
    output logic [ADDRL-1:0] ram_addr,
    output logic [7:0]       ram_din,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_HI,
        ADDR_LO,
        DATA,
        DISCARD
    } state_t;

    state_t      state;
    logic [1:0]  sck_sync;
    logic [1:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic        sck_hist;
    logic [7:0]  shreg;
    logic [2:0]  bitcnt;
    logic [15:0] addr;
    logic        wrote;

    logic        sck_s;
    logic        cs_s;
    logic        mosi_s;
    logic        sck_rise;
    logic        byte_done;
    logic [7:0]  byte_next;

    assign sck_s     = sck_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    // Edges seen while deselected are ignored.
    assign sck_rise  = sck_s & ~sck_hist & ~cs_s;
    assign byte_next = {shreg[6:0], mosi_s};
    assign byte_done = sck_rise && (bitcnt == 3'd7);

    assign busy   = ~cs_s;
    assign ram_en = ram_we;

    // cs chain resets to "deselected" so busy is low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sck_hist  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sck_hist  <= sck_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= 8'h00;
            bitcnt     <= 3'd0;
            addr       <= 16'h0000;
            wrote      <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            frame_done <= 1'b0;

            // Post-increment in the cycle after each strobe; only the
            // low ADDRL bits reach the RAM, so wrap is implicit.
            if (ram_we) begin
                addr <= addr + 16'd1;
            end

            if (state != IDLE && state != DISCARD && sck_rise) begin
                shreg  <= byte_next;
                bitcnt <= bitcnt + 3'd1;
            end

            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        state  <= CMD;
                        bitcnt <= 3'd0;
                        addr   <= 16'h0000;
                        wrote  <= 1'b0;
                    end
                end
                default: begin
                    if (cs_s) begin
                        // Deselect abandons any partial byte.
                        state      <= IDLE;
                        bitcnt     <= 3'd0;
                        addr       <= 16'h0000;
                        wrote      <= 1'b0;
                        frame_done <= (state == DATA) && wrote;
                    end else if (byte_done) begin
                        case (state)
                            CMD: begin
                                if (byte_next == CMD_WRITE) begin
                                    state <= ADDR_HI;
                                end else begin
                                    state <= DISCARD;
                                end
                            end
                            ADDR_HI: begin
                                addr[15:8] <= byte_next;
                                state      <= ADDR_LO;
                            end
                            ADDR_LO: begin
                                addr[7:0] <= byte_next;
                                state     <= DATA;
                            end
                            DATA: begin
                                ram_we   <= 1'b1;
                                ram_din  <= byte_next;
                                ram_addr <= addr[ADDRL-1:0];
                                wrote    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
